wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath width; only 64 is supported.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 in_valid  in  1  upstream (memory stage) holds a retiring instruction.
REQ-005 in_ready  out  1  stage accepts; transfer when in_valid && in_ready.
REQ-006 in_reg_write  in  1  instruction writes a destination register.
REQ-007 in_rd  in  5  destination index.
REQ-008 in_rd_is_sp  in  1  index 31 means SP, not XZR.
REQ-009 in_wb_sel  in  2  0=ALU, 1=LOAD, 2=LINK, 3 reserved (treated as ALU).
REQ-010 in_alu_result  in  64  ALU result.
REQ-011 in_pc_plus4  in  64  link value for BL/BLR.
REQ-012 in_load_size  in  2  0=byte, 1=half, 2=word, 3=dword.
REQ-013 in_load_signed  in  1  sign-extend load data.
REQ-014 in_addr_lo  in  3  load address bits [2:0].
REQ-015 dmem_rvalid / dmem_rdata  in  1 / 64  data-memory read response.
REQ-016 flush  in  1  kill any not-yet-written instruction.
REQ-017 reg_write / write_register / write_data  out  1 / 5 / 64  register-file write port.
REQ-018 busy  out  1  high while in WAIT_LOAD.

Function
REQ-019 FSM states: IDLE, WAIT_LOAD, WRITE.
REQ-020 in_ready = !reset && !flush && (state==IDLE || state==WRITE).
REQ-021 On a transfer with in_wb_sel!=LOAD, the FSM enters WRITE and latches the result; latency is 1 cycle.
REQ-022 On a transfer with in_wb_sel==LOAD, the FSM enters WAIT_LOAD and latches rd, size, signed and addr_lo.
REQ-023 In WAIT_LOAD with dmem_rvalid, the FSM latches the extended data and enters WRITE the next cycle; without dmem_rvalid it stays in WAIT_LOAD indefinitely.
REQ-024 dmem_rvalid in IDLE or WRITE is ignored.
REQ-025 In WRITE, reg_write = latched reg_write && !(rd==31 && !rd_is_sp), asserted for exactly one cycle per instruction.
REQ-026 write_register and write_data are driven from latched state; both are 0 whenever the FSM is not in WRITE.
REQ-027 In WRITE, a transfer causes back-to-back retirement (throughput 1/cycle for non-loads); without a transfer the FSM returns to IDLE.
REQ-028 LINK selects in_pc_plus4; ALU selects in_alu_result.
REQ-029 Load lane offset is addr_lo with low bits cleared to size alignment (half: [0], word: [1:0], dword: all).
REQ-030 Load extraction is rdata >> (offset*8), truncated to 8/16/32/64 bits, then zero- or sign-extended from the field MSB; in_load_signed is ignored for dword.
REQ-031 flush in WAIT_LOAD returns the FSM to IDLE with no write; a dmem_rvalid in that same cycle is discarded.
REQ-032 flush in WRITE does not suppress that cycle's write, and the next state is IDLE.
REQ-033 flush coincident with in_valid blocks the transfer (in_ready=0).

Reset
REQ-034 While reset is high, the next state is IDLE, all latches clear to 0, and in_ready=0.
REQ-035 While reset is high, reg_write, write_register, write_data and busy are 0.
REQ-036 Reset mid-load abandons the load with no write, and a later dmem_rvalid is ignored.

Structure
REQ-037 Package armcore_pkg holds: wb_sel enum (WB_ALU, WB_LOAD, WB_LINK), load-size enum, constant REG_ZR_SP=5'd31, and the FSM state enum.
REQ-038 Sub-module load_extend (combinational: rdata, size, signed, addr_lo -> 64-bit data) is instantiated once.
REQ-039 wb_stage outputs connect directly to the register-file write port.

Verification
REQ-040 ALU op with rd=5 and result 0x1234 accepted at cycle N -> reg_write=1, write_register=5, write_data=0x1234 at N+1 only.
REQ-041 Signed byte load, addr_lo=3, rdata=0x00000000_80000000, rvalid 4 cycles later -> busy for 4 cycles, then write_data=0xFFFFFFFF_FFFFFF80.
REQ-042 Unsigned half load, addr_lo=3 (aligned offset 2), rdata=0x0000_0000_BEEF_1234 -> write_data=0x000000000000BEEF.
REQ-043 rd=31: with rd_is_sp=0 -> reg_write stays 0; with rd_is_sp=1 and value 0x8000 -> writes X31=0x8000.
REQ-044 Three back-to-back ALU ops (rd 1,2,3) -> three consecutive write cycles with in_ready constantly 1.
REQ-045 Flush in WAIT_LOAD coincident with rvalid -> no write, FSM returns to IDLE, and in_ready=1 the following cycle.

Source files
------------

// File: rtl/armcore_pkg.sv
// Shared types and constants for the ARM core pipeline slice.
// Holds writeback-select, load-size and writeback FSM encodings.
package armcore_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    LS_BYTE  = 2'd0,
    LS_HALF  = 2'd1,
    LS_WORD  = 2'd2,
    LS_DWORD = 2'd3
  } load_size_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_WRITE     = 2'd2
  } wb_state_e;

  localparam logic [4:0] REG_ZR_SP = 5'd31;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Load data extractor: selects the naturally aligned lane of a 64-bit
// read response and zero- or sign-extends it to 64 bits.
module load_extend
  import armcore_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [2:0]  i_addr_lo,
  output logic [63:0] o_data
);

  logic [2:0]  w_offset;
  logic [63:0] w_shifted;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_offset = 3'd0;
    case (i_size)
      LS_BYTE:  w_offset = i_addr_lo;
      LS_HALF:  w_offset = {i_addr_lo[2:1], 1'b0};
      LS_WORD:  w_offset = {i_addr_lo[2], 2'b00};
      default:  w_offset = 3'd0;
    endcase
  end

  assign w_shifted = i_rdata >> {w_offset, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      LS_BYTE: o_data = {{56{i_signed & w_shifted[7]}},  w_shifted[7:0]};
      LS_HALF: o_data = {{48{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      LS_WORD: o_data = {{32{i_signed & w_shifted[31]}}, w_shifted[31:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU/link results in one cycle and waits for the
// data-memory response on loads, driving the register-file write port.
module wb_stage
  import armcore_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_is_sp,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [1:0]      in_load_size,
  input  logic            in_load_signed,
  input  logic [2:0]      in_addr_lo,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            flush,
  output logic            reg_write,
  output logic [4:0]      write_register,
  output logic [XLEN-1:0] write_data,
  output logic            busy
);

  wb_state_e       r_state, w_state_next;
  logic            r_reg_write, w_reg_write_next;
  logic [4:0]      r_rd, w_rd_next;
  logic            r_rd_is_sp, w_rd_is_sp_next;
  logic [XLEN-1:0] r_data, w_data_next;
  logic [1:0]      r_size, w_size_next;
  logic            r_signed, w_signed_next;
  logic [2:0]      r_addr_lo, w_addr_lo_next;

  logic            w_xfer;
  logic            w_in_write;
  logic [XLEN-1:0] w_load_data;

  load_extend u_load_extend (
    .i_rdata   (dmem_rdata),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .i_addr_lo (r_addr_lo),
    .o_data    (w_load_data)
  );

  assign in_ready = !reset && !flush && (r_state == ST_IDLE || r_state == ST_WRITE);
  assign w_xfer   = in_valid && in_ready;

  always_comb begin
    w_state_next     = r_state;
    w_reg_write_next = r_reg_write;
    w_rd_next        = r_rd;
    w_rd_is_sp_next  = r_rd_is_sp;
    w_data_next      = r_data;
    w_size_next      = r_size;
    w_signed_next    = r_signed;
    w_addr_lo_next   = r_addr_lo;

    case (r_state)
      ST_IDLE, ST_WRITE: begin
        w_state_next = ST_IDLE;
        if (w_xfer) begin
          w_reg_write_next = in_reg_write;
          w_rd_next        = in_rd;
          w_rd_is_sp_next  = in_rd_is_sp;
          if (in_wb_sel == WB_LOAD) begin
            w_size_next    = in_load_size;
            w_signed_next  = in_load_signed;
            w_addr_lo_next = in_addr_lo;
            w_state_next   = ST_WAIT_LOAD;
          end else begin
            // Reserved select value 3 falls through to the ALU result.
            w_data_next  = (in_wb_sel == WB_LINK) ? in_pc_plus4 : in_alu_result;
            w_state_next = ST_WRITE;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (flush) begin
          w_state_next = ST_IDLE;
        end else if (dmem_rvalid) begin
          w_data_next  = w_load_data;
          w_state_next = ST_WRITE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_rd_is_sp  <= 1'b0;
      r_data      <= '0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_addr_lo   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_reg_write <= w_reg_write_next;
      r_rd        <= w_rd_next;
      r_rd_is_sp  <= w_rd_is_sp_next;
      r_data      <= w_data_next;
      r_size      <= w_size_next;
      r_signed    <= w_signed_next;
      r_addr_lo   <= w_addr_lo_next;
    end
  end

  // Outputs are masked by reset too, since reset is synchronous and the state lags by a cycle.
  assign w_in_write     = (r_state == ST_WRITE) && !reset;
  assign reg_write      = w_in_write && r_reg_write && !(r_rd == REG_ZR_SP && !r_rd_is_sp);
  assign write_register = w_in_write ? r_rd : '0;
  assign write_data     = w_in_write ? r_data : '0;
  assign busy           = (r_state == ST_WAIT_LOAD) && !reset;

endmodule
